// File: rtl/flit_out_pkg.sv
// -----------------------------------------------------------------------------
// flit_out_pkg
// Shared definitions for the flit output stage.
//   STATS_WIDTH_DEFAULT : default width of the statistics counters
//   occ_t               : 2-bit occupancy (head + skid + in-flight read)
//   OCC_MAX             : maximum occupancy the stage may ever reach
// -----------------------------------------------------------------------------
package flit_out_pkg;

  localparam int STATS_WIDTH_DEFAULT = 32;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_MAX = 2'd2;

endpackage : flit_out_pkg

// File: rtl/flit_sat_counter.sv
// -----------------------------------------------------------------------------
// flit_sat_counter
// Saturating up-counter with asynchronous active-high clear.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high clear
//   inc_i   : increment request for this cycle
//   count_o : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module flit_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : flit_sat_counter

// File: rtl/flit_output_stage.sv
// -----------------------------------------------------------------------------
// flit_output_stage
// Show-ahead output stage behind a flit_buffer with one-cycle registered read
// latency. A head register and a skid register plus one in-flight read hide
// the latency and sustain one flit per cycle into a valid/ready sink.
//
// Optional feature macro: FLIT_OUT_STATS_EN
//   defined   : flit_count / stall_count are live saturating counters
//   undefined : both outputs are tied to zero, no counter flops
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   buf_not_empty  : upstream buffer has at least one flit
//   buf_data       : upstream read data, valid the cycle after buf_rd_en
//   buf_rd_en      : read strobe to the upstream buffer
//   out_valid      : head flit valid
//   out_data       : head flit
//   out_ready      : downstream accepts the head flit
//   flit_count     : flits transferred (saturating)
//   stall_count    : cycles with out_valid & ~out_ready (saturating)
// -----------------------------------------------------------------------------
module flit_output_stage
  import flit_out_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STATS_WIDTH = STATS_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buf_not_empty,
  input  logic [DATA_WIDTH-1:0]  buf_data,
  output logic                   buf_rd_en,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [STATS_WIDTH-1:0] flit_count,
  output logic [STATS_WIDTH-1:0] stall_count
);

  logic                  head_v_q, head_v_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  rd_pend_q, rd_pend_d;

  logic pop;
  logic arrival;
  occ_t occ;
  occ_t occ_after_pop;

  assign pop     = head_v_q & out_ready;
  assign arrival = rd_pend_q;

  // Occupancy counts the read already in flight, so a new read is only issued
  // when its data is guaranteed a register to land in.
  assign occ           = occ_t'(head_v_q) + occ_t'(skid_v_q) + occ_t'(rd_pend_q);
  assign occ_after_pop = occ - occ_t'(pop);

  // Gated by rst so no read reaches the buffer while both sides are clearing.
  assign buf_rd_en = ~rst & buf_not_empty & (occ_after_pop < OCC_MAX);

  assign rd_pend_d = buf_rd_en;

  always_comb begin
    head_v_d    = head_v_q;
    head_data_d = head_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;

    if (pop && skid_v_q) begin
      // Skid moves forward; a same-cycle arrival refills the skid.
      head_data_d = skid_data_q;
      if (arrival) begin
        skid_data_d = buf_data;
      end else begin
        skid_v_d = 1'b0;
      end
    end else if (pop) begin
      if (arrival) begin
        head_data_d = buf_data;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (!head_v_q) begin
      if (arrival) begin
        head_v_d    = 1'b1;
        head_data_d = buf_data;
      end
    end else begin
      // Head blocked: the late arrival parks in the skid.
      if (arrival) begin
        skid_v_d    = 1'b1;
        skid_data_d = buf_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v_q    <= 1'b0;
      head_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      head_v_q    <= head_v_d;
      head_data_q <= head_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign out_valid = head_v_q;
  assign out_data  = head_data_q;

`ifdef FLIT_OUT_STATS_EN
  flit_sat_counter #(
    .WIDTH (STATS_WIDTH)
  ) u_flit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (pop),
    .count_o (flit_count)
  );

  flit_sat_counter #(
    .WIDTH (STATS_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (head_v_q & ~out_ready),
    .count_o (stall_count)
  );
`else
  assign flit_count  = '0;
  assign stall_count = '0;
`endif

endmodule : flit_output_stage

// File: tb/tb_flit_output_stage.sv
// -----------------------------------------------------------------------------
// tb_flit_output_stage
// Upstream flit_buffer is modelled as a queue with a registered read port.
// Every flit pushed into it is also pushed into an expected-order queue; a
// negedge monitor pops and compares on every out_valid & out_ready cycle.
// -----------------------------------------------------------------------------
module tb_flit_output_stage;

  localparam int DW = 32;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          buf_not_empty;
  logic [DW-1:0] buf_data;
  logic          buf_rd_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [SW-1:0] flit_count;
  logic [SW-1:0] stall_count;

  always #5 clk = ~clk;

  flit_output_stage #(
    .DATA_WIDTH  (DW),
    .STATS_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .buf_not_empty (buf_not_empty),
    .buf_data      (buf_data),
    .buf_rd_en     (buf_rd_en),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .flit_count    (flit_count),
    .stall_count   (stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] bufq[$];
  logic [DW-1:0] expq[$];

  int cyc       = 0;
  int rd_total  = 0;
  int del_total = 0;
  int rd_cyc[$];
  int del_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream buffer model: registered read, cleared together with the stage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bufq.delete();
      buf_data <= '0;
    end else if (buf_rd_en) begin
      check("no_over_read", 64'(bufq.size() > 0), 64'd1);
      if (bufq.size() > 0) buf_data <= bufq.pop_front();
    end
  end

  // Monitor / scoreboard.
  int            mon_iss = 0;
  int            mon_pop = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_iss    = 0;
      mon_pop    = 0;
      prev_stall = 1'b0;
    end else begin
      // Reads issued but not yet delivered never exceed two.
      check("inflight_le_2", 64'((mon_iss - mon_pop) <= 2), 64'd1);
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (buf_rd_en) begin
        mon_iss++;
        rd_total++;
        rd_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        mon_pop++;
        del_total++;
        del_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          check("unexpected_flit", 64'(out_data), 64'hDEAD_0000);
        end else begin
          check("flit_data", 64'(out_data), 64'(expq.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    buf_not_empty = (bufq.size() != 0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    bufq.push_back(d);
    expq.push_back(d);
    buf_not_empty = 1'b1;
  endtask

  task automatic wait_del(input int target, input int budget, input string name);
    int n = 0;
    while (del_total < target && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(del_total >= target), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  logic [DW-1:0] f0;
  int            t0, br, bd, pushed;
  logic [SW-1:0] exp_flits, exp_stalls;

  initial begin
    rst           = 1'b1;
    out_ready     = 1'b0;
    buf_not_empty = 1'b1;   // rd_en must stay gated during reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rd_en_gated", 64'(buf_rd_en), 64'd0);
    check("rst_flit_count", 64'(flit_count), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
    buf_not_empty = 1'b0;
    rst = 1'b0;
    step();

    // Basic stream: reads on t..t+2, deliveries on t+2..t+4.
    out_ready = 1'b1;
    br = rd_cyc.size();
    bd = del_total;
    t0 = cyc;
    push(32'h11); push(32'h22); push(32'h33);
    wait_del(bd + 3, 20, "basic_timeout");
    repeat (3) step();
    check("basic_rd_count", 64'(rd_cyc.size() - br), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("basic_rd_cycle", 64'(rd_cyc[br + i] - t0), 64'(i));
      check("basic_del_cycle", 64'(del_cyc[bd + i] - t0), 64'(i + 2));
    end

    // Backpressure: only head and skid get filled, then drain without gaps.
    out_ready = 1'b0;
    br = rd_total;
    f0 = $urandom;
    push(f0);
    for (int i = 1; i < 8; i++) push($urandom);
    wait_valid(10, "bp_valid_timeout");
    repeat (6) step();
    check("bp_head_held", 64'(out_data), 64'(f0));
    check("bp_reads_total", 64'(rd_total - br), 64'd2);
    check("bp_rd_en_off", 64'(buf_rd_en), 64'd0);
    out_ready = 1'b1;
    bd = del_total;
    wait_del(bd + 8, 30, "bp_drain_timeout");
    check("bp_no_gaps", 64'(del_cyc[bd + 7] - del_cyc[bd]), 64'd7);

    // Alternating ready over 16 flits.
    bd = del_total;
    for (int i = 0; i < 16; i++) push($urandom);
    for (int i = 0; i < 200 && del_total < bd + 16; i++) begin
      out_ready = i[0];
      step();
    end
    check("alt_delivered", 64'(del_total - bd), 64'd16);

    // Random pushes with random ready.
    out_ready = 1'b1;
    bd = del_total;
    pushed = 0;
    for (int i = 0; i < 300; i++) begin
      if (pushed < 24 && $urandom_range(1, 0) == 1) begin
        push($urandom);
        pushed++;
      end
      out_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    out_ready = 1'b1;
    wait_del(bd + pushed, 60, "rand_drain_timeout");
    check("rand_delivered", 64'(del_total - bd), 64'(pushed));

    // Empty boundary: a single flit yields exactly one read and one pulse.
    repeat (2) step();
    br = rd_total;
    bd = del_total;
    push(32'hA5);
    repeat (10) step();
    check("single_reads", 64'(rd_total - br), 64'd1);
    check("single_dels", 64'(del_total - bd), 64'd1);
    check("single_idle_valid", 64'(out_valid), 64'd0);

    // Reset mid-transfer during a full-rate stream.
    bd = del_total;
    for (int i = 0; i < 10; i++) push($urandom);
    wait_del(bd + 3, 20, "mid_timeout");
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_rd_en", 64'(buf_rd_en), 64'd1);
    expq.delete();
    rst = 1'b1;
    #1;
    buf_not_empty = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rd_en", 64'(buf_rd_en), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_data", 64'(out_data), 64'd0);
    check("post_rst_rd_en", 64'(buf_rd_en), 64'd0);
    check("post_rst_flit_count", 64'(flit_count), 64'd0);
    check("post_rst_stall_count", 64'(stall_count), 64'd0);

    // Stats: 5 accepts, 3 stall cycles.
    out_ready = 1'b0;
    bd = del_total;
    for (int i = 0; i < 5; i++) push($urandom);
    wait_valid(10, "stats_valid_timeout");
    step();
    step();
    step();
    out_ready = 1'b1;
    wait_del(bd + 5, 20, "stats_drain_timeout");
    step();
`ifdef FLIT_OUT_STATS_EN
    exp_flits  = SW'(5);
    exp_stalls = SW'(3);
`else
    exp_flits  = '0;
    exp_stalls = '0;
`endif
    check("stats_flit_count", 64'(flit_count), 64'(exp_flits));
    check("stats_stall_count", 64'(stall_count), 64'(exp_stalls));

    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_flit_output_stage
